// File: rtl/fpu_pkg.sv
// Shared FPU types: normalizer source IDs, operand bundle and pipeline tag.
package fpu_pkg;

    typedef enum logic [1:0] {
        SRC_ADDSUB = 2'd0,
        SRC_MUL    = 2'd1,
        SRC_DIV    = 2'd2
    } src_id_t;

    localparam int NUM_NORM_SOURCES = 3;

    typedef struct packed {
        logic [9:0]  exponent;
        logic [48:0] fraction;
    } norm_operand_t;

    typedef struct packed {
        logic    valid;
        src_id_t src;
    } norm_tag_t;

    function automatic src_id_t next_src(input src_id_t s);
        case (s)
            SRC_ADDSUB: return SRC_MUL;
            SRC_MUL:    return SRC_DIV;
            default:    return SRC_ADDSUB;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; the pointer moves one past each winner.
module rr_arbiter3
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] eligible,
    output logic [2:0] grant
);

    src_id_t ptr;
    src_id_t idx;
    logic    found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_NORM_SOURCES; k++) begin
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = next_src(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= SRC_ADDSUB;
        end else if (grant[0]) begin
            ptr <= SRC_MUL;
        end else if (grant[1]) begin
            ptr <= SRC_DIV;
        end else if (grant[2]) begin
            ptr <= SRC_ADDSUB;
        end
    end

endmodule

// File: rtl/normalizer_arbiter.sv
// Shares one fixed-latency normalizer between add/sub, mul and div producers,
// tagging each issue so the result is routed back to its owner.
module normalizer_arbiter
    import fpu_pkg::*;
#(
    parameter int NORM_LATENCY    = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [2:0][9:0]   req_exponent,
    input  logic [2:0][48:0]  req_fraction,
    output logic              norm_issue_valid,
    output logic [9:0]        norm_issue_exponent,
    output logic [48:0]       norm_issue_fraction,
    input  logic              norm_result_valid,
    input  logic [9:0]        norm_result_exponent,
    input  logic [23:0]       norm_result_fraction,
    output logic [2:0]        done_valid,
    output logic [9:0]        done_exponent,
    output logic [23:0]       done_fraction
);

    localparam int QW = $clog2(NORM_LATENCY + 1) + 1;

    logic [2:0]    eligible;
    logic [2:0]    grant;
    src_id_t       winner;
    norm_operand_t issue_op;
    norm_tag_t     tag_q [NORM_LATENCY+1];
    norm_tag_t     last;
    logic [2:0]    outstanding [NUM_NORM_SOURCES];
    logic [QW-1:0] quiet;

    // Nothing is accepted in a reset cycle, so producers never see a lost grant.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_NORM_SOURCES; i++) begin
            eligible[i] = !reset && req_valid[i] && (outstanding[i] < 3'(MAX_OUTSTANDING));
        end
    end

    rr_arbiter3 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready = grant;

    always_comb begin
        winner = SRC_ADDSUB;
        if (grant[1]) winner = SRC_MUL;
        if (grant[2]) winner = SRC_DIV;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            norm_issue_valid <= 1'b0;
            issue_op         <= '0;
        end else begin
            norm_issue_valid <= |grant;
            if (|grant) begin
                issue_op <= '{exponent: req_exponent[winner], fraction: req_fraction[winner]};
            end
        end
    end

    assign norm_issue_exponent = issue_op.exponent;
    assign norm_issue_fraction = issue_op.fraction;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= NORM_LATENCY; k++) begin
                tag_q[k] <= '{valid: 1'b0, src: SRC_ADDSUB};
            end
        end else begin
            tag_q[0] <= '{valid: |grant, src: winner};
            for (int k = 1; k <= NORM_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign last = tag_q[NORM_LATENCY];

    // The tag, not norm_result_valid, decides completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_valid    <= '0;
            done_exponent <= '0;
            done_fraction <= '0;
        end else begin
            done_valid <= last.valid ? (3'b001 << last.src) : 3'b000;
            if (last.valid) begin
                done_exponent <= norm_result_exponent;
                done_fraction <= norm_result_fraction;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_NORM_SOURCES; i++) outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_NORM_SOURCES; i++) begin
                case ({grant[i], done_valid[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + 3'd1;
                    2'b01:   outstanding[i] <= outstanding[i] - 3'd1;
                    default: outstanding[i] <= outstanding[i];
                endcase
            end
        end
    end

    // Results issued before reset may still drain out of the normalizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            quiet <= QW'(NORM_LATENCY);
        end else if (quiet != '0) begin
            quiet <= quiet - QW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && quiet == '0) begin
            assert (norm_result_valid == last.valid)
                else $error("norm_result_valid disagrees with delay-line tag");
        end
    end

endmodule

// File: tb/tb_normalizer_arbiter.sv
// Bench for normalizer_arbiter: directed scenarios then random traffic,
// checked against a scoreboard of accepted operations and their due cycles.
module tb_normalizer_arbiter;

    localparam int L    = 3;
    localparam int MAXO = 4;

    logic             clk;
    logic             reset;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][9:0]  req_exponent;
    logic [2:0][48:0] req_fraction;
    logic             norm_issue_valid;
    logic [9:0]       norm_issue_exponent;
    logic [48:0]      norm_issue_fraction;
    logic             norm_result_valid;
    logic [9:0]       norm_result_exponent;
    logic [23:0]      norm_result_fraction;
    logic [2:0]       done_valid;
    logic [9:0]       done_exponent;
    logic [23:0]      done_fraction;

    normalizer_arbiter #(.NORM_LATENCY(L), .MAX_OUTSTANDING(MAXO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_exponent         (req_exponent),
        .req_fraction         (req_fraction),
        .norm_issue_valid     (norm_issue_valid),
        .norm_issue_exponent  (norm_issue_exponent),
        .norm_issue_fraction  (norm_issue_fraction),
        .norm_result_valid    (norm_result_valid),
        .norm_result_exponent (norm_result_exponent),
        .norm_result_fraction (norm_result_fraction),
        .done_valid           (done_valid),
        .done_exponent        (done_exponent),
        .done_fraction        (done_fraction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normalizer stand-in: L-cycle echo of exponent and fraction[47:24]; not reset.
    logic        pv [L];
    logic [9:0]  pe [L];
    logic [23:0] pf [L];
    always @(posedge clk) begin
        pv[0] <= norm_issue_valid;
        pe[0] <= norm_issue_exponent;
        pf[0] <= norm_issue_fraction[47:24];
        for (int k = 1; k < L; k++) begin
            pv[k] <= pv[k-1];
            pe[k] <= pe[k-1];
            pf[k] <= pf[k-1];
        end
    end
    assign norm_result_valid    = pv[L-1];
    assign norm_result_exponent = pe[L-1];
    assign norm_result_fraction = pf[L-1];

    typedef struct {
        int          src;
        int          due;
        logic [9:0]  e;
        logic [23:0] f;
    } pend_t;

    pend_t       pend[$];
    int          vectors;
    int          miscompares;
    int          cyc;
    int          ptr_m;
    logic        acc_v;
    logic [9:0]  acc_e;
    logic [48:0] acc_f;
    logic [2:0]  rdy_s;
    logic [2:0]  done_s;

    function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endfunction

    // One clock cycle: compare outputs with the scoreboard, then advance it.
    task automatic step();
        int         cnt [3];
        int         w;
        logic [2:0] exp_done;
        logic [2:0] exp_rdy;
        logic [9:0] de;
        logic [23:0] df;
        @(negedge clk);
        rdy_s  = req_ready;
        done_s = done_valid;
        check("issue_valid", norm_issue_valid, acc_v);
        if (acc_v) begin
            check("issue_exponent", norm_issue_exponent, acc_e);
            check("issue_fraction", norm_issue_fraction, acc_f);
        end
        exp_done = 3'b000;
        de = '0;
        df = '0;
        foreach (pend[n]) begin
            if (pend[n].due == cyc) begin
                exp_done = 3'(1 << pend[n].src);
                de = pend[n].e;
                df = pend[n].f;
            end
        end
        check("done_valid", done_valid, exp_done);
        if (exp_done != 3'b000) begin
            check("done_exponent", done_exponent, de);
            check("done_fraction", done_fraction, df);
        end
        if (reset) begin
            pend.delete();
            ptr_m = 0;
            acc_v = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt[i] = 0;
                foreach (pend[n]) if (pend[n].src == i && pend[n].due >= cyc) cnt[i]++;
            end
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (ptr_m + k) % 3;
                if (w < 0 && req_valid[j] && cnt[j] < MAXO) w = j;
            end
            exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
            check("req_ready", req_ready, exp_rdy);
            if (w >= 0) begin
                pend.push_back('{src: w, due: cyc + L + 2, e: req_exponent[w], f: req_fraction[w][47:24]});
                ptr_m = (w + 1) % 3;
                acc_v = 1'b1;
                acc_e = req_exponent[w];
                acc_f = req_fraction[w];
            end else begin
                acc_v = 1'b0;
            end
        end
        for (int n = pend.size() - 1; n >= 0; n--) begin
            if (pend[n].due <= cyc) pend.delete(n);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        req_valid = 3'b000;
        repeat (n) step();
    endtask

    logic [2:0] seq [8];
    logic [2:0] exp3;
    logic [7:0] exp_r;
    logic [7:0] got_r;
    int         grants;

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        ptr_m = 0;
        acc_v = 1'b0;
        acc_e = '0;
        acc_f = '0;
        reset = 1'b1;
        req_valid = 3'b000;
        req_exponent = '0;
        req_fraction = '0;

        repeat (3) step();
        reset = 1'b0;
        check("rst_issue_valid", norm_issue_valid, 1'b0);
        check("rst_issue_exponent", norm_issue_exponent, 10'h000);
        check("rst_issue_fraction", norm_issue_fraction, 49'h0);
        check("rst_done_valid", done_valid, 3'b000);
        check("rst_done_exponent", done_exponent, 10'h000);
        check("rst_done_fraction", done_fraction, 24'h0);

        // All three continuously valid: strict rotation.
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            req_exponent[i] = 10'(i + 1);
            req_fraction[i] = 49'(i + 5) << 30;
        end
        for (int i = 0; i < 6; i++) begin
            step();
            seq[i] = rdy_s;
        end
        for (int i = 0; i < 6; i++) begin
            exp3 = 3'b001 << (i % 3);
            check("rotation", seq[i], exp3);
        end
        drain(8);

        // Single mul op: done five cycles after accept.
        req_valid = 3'b010;
        req_exponent[1] = 10'h07F;
        req_fraction[1] = 49'h1_0000_0000_0000;
        step();
        check("mul_accept", rdy_s, 3'b010);
        req_valid = 3'b000;
        repeat (4) step();
        check("mul_done_valid", done_valid, 3'b010);
        check("mul_done_exponent", done_exponent, 10'h07F);
        drain(4);

        // div alone: four grants, blocked until its first done, regrant after.
        req_valid = 3'b100;
        req_exponent[2] = 10'h155;
        for (int i = 0; i < 8; i++) begin
            req_fraction[2] = 49'({$urandom(), $urandom()});
            step();
            got_r[i] = rdy_s[2];
            seq[i]   = done_s;
        end
        grants = 0;
        for (int i = 0; i < 4; i++) if (got_r[i]) grants++;
        check("div_grant_count", grants, 4);
        check("div_blocked_c4", got_r[4], 1'b0);
        check("div_blocked_at_done", got_r[5], 1'b0);
        check("div_first_done", seq[5], 3'b100);
        check("div_regrant", got_r[6], 1'b1);
        drain(10);

        // Pointer at 1 with addsub and div requesting: div first.
        req_valid = 3'b001;
        step();
        check("ptr_setup", rdy_s, 3'b001);
        req_valid = 3'b101;
        step();
        check("ptr1_first", rdy_s, 3'b100);
        step();
        check("ptr1_second", rdy_s, 3'b001);
        drain(10);

        // Reset with operations in flight.
        req_valid = 3'b111;
        repeat (3) step();
        req_valid = 3'b001;
        step();
        reset = 1'b1;
        req_valid = 3'b111;
        step();
        reset = 1'b0;
        req_valid = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_no_done", done_s, 3'b000);
        end
        req_valid = 3'b111;
        step();
        check("post_reset_first_grant", rdy_s, 3'b001);
        drain(10);

        // addsub at the cap while its done arrives: blocked that cycle.
        req_valid = 3'b001;
        for (int i = 0; i < 8; i++) begin
            step();
            got_r[i] = rdy_s[0];
            seq[i]   = done_s;
        end
        exp_r = 8'b1100_1111;
        check("addsub_cap_pattern", got_r, exp_r);
        check("addsub_done_coincide", seq[4], 3'b000);
        check("addsub_done_at_cap", seq[5], 3'b001);
        drain(10);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req_valid = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 99) == 0);
            for (int s = 0; s < 3; s++) begin
                req_exponent[s] = 10'($urandom());
                req_fraction[s] = 49'({$urandom(), $urandom()});
            end
            step();
        end
        reset = 1'b0;
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/normalizer_arbiter.md
Name: normalizer_arbiter

Overview:
- Shares one fully pipelined normalizer (exponent select + shift + round) between three producers: add/sub, mul, div.
- Round-robin arbitration over valid/ready requests; the winner's operand is registered into the normalizer issue stage.
- A source-ID delay line tracks each issue through the fixed-latency pipeline and routes the result back to the issuing producer.
- Per-source outstanding counters cap in-flight operations so producer result buffers cannot overflow.

Parameters:
- NORM_LATENCY, 3, cycles from norm_issue_valid to norm_result_valid for the same operation (>=1).
- MAX_OUTSTANDING, 4, maximum in-flight operations per source (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  3  request valid per source; [0]=addsub, [1]=mul, [2]=div
- req_ready  output  3  request accepted this cycle (one-hot or zero)
- req_exponent  input  3x10  calculated exponent per source
- req_fraction  input  3x49  unnormalized fraction per source, 2 integer + 47 fractional bits
- norm_issue_valid  output  1  issue-stage valid into the normalizer
- norm_issue_exponent  output  10  registered exponent of the winning request
- norm_issue_fraction  output  49  registered fraction of the winning request
- norm_result_valid  input  1  normalizer output valid
- norm_result_exponent  input  10  normalized exponent
- norm_result_fraction  input  24  normalized and rounded mantissa
- done_valid  output  3  one-hot result strobe to the owning source
- done_exponent  output  10  result exponent, broadcast to all sources
- done_fraction  output  24  result mantissa, broadcast to all sources

Behaviour:
- Reset applies on a clk edge with reset=1:
  - norm_issue_valid=0; issue exponent and fraction registers=0.
  - done_valid=0; priority pointer=0 (addsub highest).
  - All outstanding counters=0; delay line cleared to invalid.
  - Reset has priority over every other event in the same cycle. Operations in flight at reset are discarded, and any norm_result_valid already in the pipeline is ignored until NORM_LATENCY cycles after reset deasserts.
- Eligibility: source i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Arbitration (combinational, same cycle):
  - Search starts at the priority pointer, wrapping 0->1->2->0. The first eligible source wins.
  - req_ready = one-hot of the winner, or 0 if none is eligible.
  - req_ready never depends on norm_result_valid, because the pipeline never stalls.
- Pointer update: after a grant to source g, pointer <= (g+1) mod 3. With no grant, the pointer holds.
- Issue stage:
  - norm_issue_valid <= |req_ready every cycle, so one operation can issue per cycle with no bubbles.
  - Exponent and fraction registers load the winner's data on a grant. Otherwise they hold their value (don't-care when invalid).
  - Latency from req_valid&req_ready to norm_issue_valid is 1 cycle.
- Delay line:
  - NORM_LATENCY+1 stages of {valid, src[1:0]}, shifting every cycle.
  - Stage 0 captures {grant, winner id}. The last stage aligns with norm_result_valid.
- Completion:
  - When the last stage is valid, done_valid <= onehot(src). done_exponent and done_fraction are registered from the norm_result_* inputs on that cycle.
  - Total latency from accept to done_valid = NORM_LATENCY + 2 cycles.
  - If norm_result_valid disagrees with the last stage's valid bit, that is a protocol error: flag it with a simulation-only assertion and ignore norm_result_valid (the delay line is authoritative).
- Outstanding counters (3 bits, saturation-free by construction):
  - Increment on grant to i; decrement when done_valid[i] is asserted.
  - Grant and done for the same source in the same cycle leave the count unchanged.
  - A count of MAX_OUTSTANDING blocks that source until a done frees a slot; the freed slot is usable in the cycle after done_valid.
- Boundary cases:
  - All three sources continuously valid: strict rotation 0,1,2,0,... with one grant per cycle.
  - A single eligible source gets back-to-back grants each cycle until it hits MAX_OUTSTANDING.
  - A requester dropping req_valid without a grant is legal; no state changes.

Decomposition:
- Shared package fpu_pkg:
  - Typedef src_id_t (2-bit, enum SRC_ADDSUB=0, SRC_MUL=1, SRC_DIV=2); constant NUM_NORM_SOURCES=3.
  - Typedef norm_operand_t {exponent[9:0], fraction[48:0]}.
  - Typedef norm_tag_t {valid, src_id_t}.
- Sub-module rr_arbiter3: combinational round-robin search plus pointer register, with inputs eligible[2:0] and outputs grant[2:0]. It is reusable for other shared FPU resources.
- Delay line, counters and issue register stay in the top.

Test Plan:
- Reset then req_valid=3'b111 held 6 cycles -> req_ready sequence 001,010,100,001,010,100; norm_issue_valid high from cycle 2.
- Only mul valid, exponent=10'h07F, fraction=49'h1_0000_0000_0000, normalizer model echoes -> done_valid=3'b010 exactly 5 cycles (NORM_LATENCY+2) after accept, done_exponent=10'h07F.
- div held valid, no completions returned -> exactly 4 grants, then req_ready[2]=0 until first done_valid[2], regrant in the following cycle.
- Pointer at 1, req_valid=3'b101 -> div (2) granted first, then addsub (0) next cycle.
- Reset asserted with 3 ops in flight -> no done_valid within the next 5 cycles, all counters 0, first post-reset grant goes to addsub.
- Grant to addsub coinciding with done_valid[0] at outstanding=4 -> counter stays 4, req_ready[0]=0 that cycle (eligibility uses the registered count).
